// File: rtl/lane_serializer_pkg.sv
// rtl/lane_serializer_pkg.sv - shared state encoding, default widths and clog2 helper
package lane_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int LANE_W_DEF = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lane_serializer_if.sv
// rtl/lane_serializer_if.sv - word-in / lane-out handshake bundle
interface lane_serializer_if
  #(parameter int DATA_W = lane_serializer_pkg::DATA_W_DEF,
    parameter int LANE_W = lane_serializer_pkg::LANE_W_DEF);
  import lane_serializer_pkg::*;

  localparam int LANES = DATA_W / LANE_W;
  localparam int IDX_W = (clog2(LANES) > 1) ? clog2(LANES) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_rev;
  logic              in_msb_first;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_lane;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_rev, in_msb_first, out_ready,
    input  in_ready, out_valid, out_lane, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_rev, in_msb_first, out_ready,
    output in_ready, out_valid, out_lane, out_idx, out_last
  );

endinterface

// File: rtl/lane_serializer_bit_reverse.sv
// rtl/lane_serializer_bit_reverse.sv - combinational bit-order reversal of a W-bit vector
module bit_reverse #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  for (genvar k = 0; k < W; k++) begin : g_rev
    assign dout[k] = din[W-1-k];
  end

endmodule

// File: rtl/lane_serializer.sv
// rtl/lane_serializer.sv - splits a word into lanes emitted one per cycle on a valid/ready stream
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input logic              clk,
  input logic              reset,
  lane_serializer_if.slave bus
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int IDX_W = (clog2(LANES) > 1) ? clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(LANES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q;
  logic              rev_q;
  logic              msb_q;

  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] lane_sel;
  logic [LANE_W-1:0] lane_rev;
  logic              last;
  logic              accept;
  logic              xfer;

  // Outputs decode only registered state, so in_data never reaches them combinationally.
  assign idx      = msb_q ? (LAST_CNT - cnt_q) : cnt_q;
  assign lane_sel = word_q[int'(idx) * LANE_W +: LANE_W];

  bit_reverse #(.W(LANE_W)) u_bit_reverse (
    .din  (lane_sel),
    .dout (lane_rev)
  );

  assign last          = (state_q == SEND) && (cnt_q == LAST_CNT);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_idx   = idx;
  assign bus.out_lane  = rev_q ? lane_rev : lane_sel;
  assign bus.out_last  = last;
  assign bus.in_ready  = (state_q == IDLE) || (last && bus.out_ready);

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last) begin
            state_d = accept ? SEND : IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      rev_q   <= 1'b0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        word_q <= bus.in_data;
        rev_q  <= bus.in_rev;
        msb_q  <= bus.in_msb_first;
      end
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// tb/tb_lane_serializer.sv - directed self-checking bench for lane_serializer
module tb_lane_serializer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  lane_serializer_if #(.DATA_W(32), .LANE_W(8)) bus_a ();
  lane_serializer_if #(.DATA_W(16), .LANE_W(4)) bus_b ();

  lane_serializer #(.DATA_W(32), .LANE_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  lane_serializer #(.DATA_W(16), .LANE_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input string tag, input logic [31:0] data, input logic rev, input logic msb);
    bus_a.in_data      = data;
    bus_a.in_rev       = rev;
    bus_a.in_msb_first = msb;
    bus_a.in_valid     = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus_a.in_ready), 32'd1);
    next_cycle();
    bus_a.in_valid     = 1'b0;
    bus_a.in_rev       = ~rev;
    bus_a.in_msb_first = ~msb;
  endtask

  // exp holds the lanes in emission order, first lane in the top byte.
  task automatic drain_a(input string tag, input logic [31:0] exp, input logic msb);
    logic [31:0] exp_idx;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_idx = msb ? 32'(3 - i) : 32'(i);
      @(negedge clk);
      check({tag, "_valid"}, 32'(bus_a.out_valid), 32'd1);
      check({tag, "_lane"}, 32'(bus_a.out_lane), 32'(exp[31 - 8*i -: 8]));
      check({tag, "_idx"}, 32'(bus_a.out_idx), exp_idx);
      check({tag, "_last"}, 32'(bus_a.out_last), (i == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
  endtask

  task automatic expect_idle_a(input string tag);
    @(negedge clk);
    check({tag, "_idle_valid"}, 32'(bus_a.out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus_a.in_ready), 32'd1);
  endtask

  logic [7:0]  bp_lanes [4];
  logic        bp_ready [8];
  logic [7:0]  held_lane;
  logic [3:0]  b_lanes [4];
  int          k;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_rev = 1'b0;
    bus_a.in_msb_first = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_rev = 1'b0;
    bus_b.in_msb_first = 1'b0; bus_b.out_ready = 1'b0;

    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_lane", 32'(bus_a.out_lane), 32'd0);
    check("rst_idx", 32'(bus_a.out_idx), 32'd0);
    check("rst_last", 32'(bus_a.out_last), 32'd0);
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_emit", 32'(bus_a.out_valid), 32'd0);
      check("idle_in_ready", 32'(bus_a.in_ready), 32'd1);
      next_cycle();
    end

    bus_a.out_ready = 1'b1;
    send_a("classic", 32'h12345678, 1'b1, 1'b1);
    drain_a("classic", 32'h482C6A1E, 1'b1);
    expect_idle_a("classic");
    next_cycle();

    send_a("plain", 32'h12345678, 1'b0, 1'b0);
    drain_a("plain", 32'h78563412, 1'b0);
    expect_idle_a("plain");
    next_cycle();

    // Backpressure on word 1, then word 2 offered during its last lane.
    bp_lanes = '{8'h78, 8'h56, 8'h34, 8'h12};
    bp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    send_a("bp", 32'h12345678, 1'b0, 1'b0);
    k = 0;
    held_lane = 8'h00;
    for (int j = 0; j < 8; j++) begin
      bus_a.out_ready = bp_ready[j];
      if (k == 3) begin
        bus_a.in_valid     = 1'b1;
        bus_a.in_data      = 32'hAABBCCDD;
        bus_a.in_rev       = 1'b0;
        bus_a.in_msb_first = 1'b0;
      end
      @(negedge clk);
      check("bp_valid", 32'(bus_a.out_valid), 32'd1);
      check("bp_lane", 32'(bus_a.out_lane), 32'(bp_lanes[k]));
      check("bp_idx", 32'(bus_a.out_idx), 32'(k));
      check("bp_last", 32'(bus_a.out_last), (k == 3) ? 32'd1 : 32'd0);
      if (j > 0 && !bp_ready[j-1])
        check("bp_stable", 32'(bus_a.out_lane), 32'(held_lane));
      if (k == 3)
        check("bp_in_ready", 32'(bus_a.in_ready), 32'(bp_ready[j]));
      held_lane = bus_a.out_lane;
      next_cycle();
      if (bp_ready[j]) k++;
    end
    check("bp_lanes_done", 32'(k), 32'd4);
    bus_a.in_valid = 1'b0;
    bus_a.in_rev   = 1'b1;
    drain_a("b2b", 32'hDDCCBBAA, 1'b0);
    expect_idle_a("b2b");
    next_cycle();

    send_a("midrst", 32'hDEADBEEF, 1'b0, 1'b0);
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_lane", 32'(bus_a.out_lane), (i == 0) ? 32'hEF : 32'hBE);
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(bus_a.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("midrst_out_lane", 32'(bus_a.out_lane), 32'd0);
    next_cycle();
    send_a("after_rst", 32'hAABBCCDD, 1'b0, 1'b0);
    drain_a("after_rst", 32'hDDCCBBAA, 1'b0);
    expect_idle_a("after_rst");
    next_cycle();

    b_lanes = '{4'h8, 4'h4, 4'hC, 4'h2};
    bus_b.in_data      = 16'h1234;
    bus_b.in_rev       = 1'b1;
    bus_b.in_msb_first = 1'b1;
    bus_b.in_valid     = 1'b1;
    bus_b.out_ready    = 1'b1;
    @(negedge clk);
    check("p16_in_ready", 32'(bus_b.in_ready), 32'd1);
    next_cycle();
    bus_b.in_valid     = 1'b0;
    bus_b.in_rev       = 1'b0;
    bus_b.in_msb_first = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("p16_valid", 32'(bus_b.out_valid), 32'd1);
      check("p16_lane", 32'(bus_b.out_lane), 32'(b_lanes[i]));
      check("p16_idx", 32'(bus_b.out_idx), 32'(3 - i));
      check("p16_last", 32'(bus_b.out_last), (i == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check("p16_idle", 32'(bus_b.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Parametrised, handshaked successor to the combinational byte splitter. Accepts one DATA_W-bit word, cuts it into LANE_W-bit lanes and emits them one per cycle on a valid/ready stream. The per-word mode selects lane order and per-lane bit reversal. Sits between a word-wide producer (register file or memory read port) and a narrow consumer (byte-wide display, UART or memory write path).

## Interface
- DATA_W, 32, input word width; must be a positive multiple of LANE_W.
- LANE_W, 8, lane width in bits.
- LANES, DATA_W/LANE_W, derived lane count; not overridable.
- IDX_W, max(1, clog2(LANES)), derived width of the lane index.

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers a word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DATA_W  word to split.
- in_rev  input  1  bit-reverse each lane; sampled with the word.
- in_msb_first  input  1  emit the top lane first; sampled with the word.
- out_valid  output  1  out_lane holds a valid lane.
- out_ready  input  1  consumer takes the lane this cycle.
- out_lane  output  LANE_W  current lane, after optional reversal.
- out_idx  output  IDX_W  source lane number of out_lane; lane 0 is in_data[LANE_W-1:0].
- out_last  output  1  current lane is the final lane of its word.

## Operation
- The block has two states: IDLE and SEND.
- Reset puts the block in IDLE and clears every output and register to 0: out_valid=0, out_lane=0, out_idx=0, out_last=0. in_ready=1 in IDLE, including the first cycle after reset.
- Accept: a word is accepted when in_valid && in_ready. On accept the block latches in_data, in_rev and in_msb_first into a word register and moves to SEND.
- Lane counter cnt runs 0..LANES-1 within a word:
  - with msb_first=1, out_idx = LANES-1-cnt;
  - with msb_first=0, out_idx = cnt.
- out_lane is lane[out_idx] of the latched word. When rev=1, it is bit-reversed: out_lane[k] = lane[LANE_W-1-k].
- Transfer: a lane transfers when out_valid && out_ready, and cnt then increments.
  - On the transfer with out_last=1 (cnt==LANES-1), the block returns to IDLE.
  - If a new word is accepted in that same cycle, the block stays in SEND with cnt=0.
- in_ready = (state==IDLE) || (out_last && out_ready). The second term gives back-to-back words with no bubble.
- out_valid must stay high and out_lane/out_idx/out_last must stay stable while out_ready=0.
- Mode inputs are ignored except on the accept cycle. Mode changes during SEND do not affect the word in flight.
- LANES==1: every lane is last; the block behaves as a one-entry pipeline register with optional reversal.
- Reset asserted mid-word discards the remaining lanes. Next cycle the block is in IDLE with reset values.

## Timing
- Latency from accept to first lane: 1 cycle. out_valid rises in the cycle after the in_valid && in_ready edge.
- Throughput: one lane per cycle under continuous out_ready. A word takes LANES cycles. Back-to-back words sustain 100% lane throughput.
- All outputs are registered except in_ready, which is combinational from state, out_last and out_ready.
- No combinational path from in_data to any output.

## Structure
- The shared header/package holds:
  - the state encoding: IDLE=1'b0, SEND=1'b1;
  - the default widths DATA_W_DEF=32 and LANE_W_DEF=8;
  - a clog2 function for IDX_W.
- Sub-module bit_reverse #(W) is purely combinational: out[k] = in[W-1-k]. It is instanced once on the selected lane.
- Lane selection is an indexed part-select on the word register, driven by out_idx.

## Test plan
- Reset then idle:
  - hold reset 2 cycles -> out_valid=0, out_lane=0, in_ready=1;
  - in_valid=0 -> nothing emitted.
- Classic mode: in_data=0x12345678, rev=1, msb_first=1, out_ready=1 -> lanes 0x48, 0x2C, 0x6A, 0x1E; out_idx 3, 2, 1, 0; out_last only on 0x1E.
- Plain little-endian: in_data=0x12345678, rev=0, msb_first=0 -> lanes 0x78, 0x56, 0x34, 0x12; out_idx 0, 1, 2, 3.
- Backpressure and back-to-back:
  - out_ready toggled 1,0,0,1,… -> lanes held stable while stalled;
  - second word 0xAABBCCDD presented during the last lane -> in_ready=1 that cycle, first lane of the new word follows with no gap.
- Mid-word reset: assert reset after 2 lanes of 0xDEADBEEF -> next cycle out_valid=0, in_ready=1; a following word emits all 4 lanes from cnt=0.
- Parametrisation: DATA_W=16, LANE_W=4, in_data=0x1234, rev=1, msb_first=1 -> lanes 0x8, 0x4, 0xC, 0x2.
